// File: rtl/led_matrix_row_scanner_pkg.sv
// Shared types and constants for the 5x7 LED matrix row scanner.
package led_matrix_row_scanner_pkg;

    localparam int ROWS = 7;
    localparam int COLS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam logic [ROWS-1:0] ROW_OFF = 7'h7F;

    // Active-low one-hot row drive for row idx.
    function automatic logic [ROWS-1:0] row_drive(input logic [2:0] idx);
        return ROW_OFF ^ (ROWS'(1) << idx);
    endfunction

endpackage

// File: rtl/led_matrix_row_scanner_row_slot_counter.sv
// Row slot timer: counts the DIV-cycle slot, flagging end of blanking and end of slot.
module led_matrix_row_scanner_row_slot_counter
    import led_matrix_row_scanner_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic blank_done,
    output logic slot_end
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign blank_done = (cnt_q == CW'(BLANK - 1));
    assign slot_end   = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || slot_end) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_matrix_row_scanner.sv
// Scans a 5x7 LED matrix one row per slot, with blanking between rows and a
// shadow copy of the patterns taken once per frame so a frame never tears.
module led_matrix_row_scanner
    import led_matrix_row_scanner_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] pattern_in,
    output logic [ROWS-1:0]      row_n,
    output logic [COLS-1:0]      col,
    output logic [2:0]           row_idx,
    output logic                 frame_start
);

    state_e                     state_q, state_d;
    logic [2:0]                 row_idx_q, row_idx_d;
    logic [ROWS-1:0][COLS-1:0]  shadow_q, shadow_d;
    logic [ROWS-1:0]            row_n_q, row_n_d;
    logic [COLS-1:0]            col_q, col_d;
    logic                       frame_start_q, frame_start_d;
    logic                       blank_done, slot_end, cnt_clear;

    // Hold the counter at zero while idle so the first slot starts cleanly.
    assign cnt_clear = !enable || (state_q == ST_IDLE);

    led_matrix_row_scanner_row_slot_counter #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_row_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .blank_done (blank_done),
        .slot_end   (slot_end)
    );

    always_comb begin
        state_d       = state_q;
        row_idx_d     = row_idx_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;
        if (!enable) begin
            state_d   = ST_IDLE;
            row_idx_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d       = ST_BLANK;
                    row_idx_d     = '0;
                    shadow_d      = pattern_in;
                    frame_start_d = 1'b1;
                end
                ST_BLANK: if (blank_done) state_d = ST_SHOW;
                ST_SHOW: if (slot_end) begin
                    state_d = ST_BLANK;
                    if (row_idx_q == 3'(ROWS - 1)) begin
                        row_idx_d     = '0;
                        shadow_d      = pattern_in;
                        frame_start_d = 1'b1;
                    end else begin
                        row_idx_d = row_idx_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Outputs follow the next state so they line up with the registered state.
        row_n_d = (state_d == ST_SHOW) ? row_drive(row_idx_d) : ROW_OFF;
        col_d   = (state_d == ST_SHOW) ? shadow_d[row_idx_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_idx_q     <= '0;
            shadow_q      <= '0;
            row_n_q       <= ROW_OFF;
            col_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            shadow_q      <= shadow_d;
            row_n_q       <= row_n_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_n       = row_n_q;
    assign col         = col_q;
    assign row_idx     = row_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/led_matrix_row_scanner.md
Name: led_matrix_row_scanner

Overview:
- Time-multiplexed driver for the 5x7 LED dot matrix; the consuming end of the per-line preset pattern generators.
- Each preset line block produces a 5-bit column pattern from the 2-bit display code.
- This block latches all 7 line patterns once per frame into a shadow register.
- It then scans the rows one at a time, driving one active-low row and the matching active-high column bits, with a blanking gap between rows to prevent ghosting.

Parameters:
- DIV, 50000, clock cycles per row slot; must satisfy DIV > BLANK.
- BLANK, 2, cycles at the start of each row slot with all rows off and columns 0; must be >= 1.
- ROWS, 7, matrix rows (lines); fixed, not intended to be overridden.
- COLS, 5, matrix columns; fixed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  high = scan the matrix; low = display dark.
- pattern_in  input  35  row r (line r+1) columns at bits [5r+4:5r]; bit 5r+4 = leftmost column (cl[4]).
- row_n  output  7  one-hot-low row drive; 7'h7F = all rows off.
- col  output  5  column drive for the active row, active-high.
- row_idx  output  3  row currently being scanned, 0..6.
- frame_start  output  1  one-cycle pulse when row 0 slot begins (shadow latched).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- All outputs are registered.
- Reset (rst_n sampled low at an edge) forces:
  - state IDLE, slot counter 0, row_idx 0;
  - row_n 7'h7F, col 0, frame_start 0, shadow 0.
- Reset overrides every other input in that cycle.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - row_n 7'h7F, col 0.
  - enable high -> BLANK with row_idx 0, shadow <= pattern_in, frame_start 1 for exactly that cycle, counter 0.
- BLANK:
  - row_n 7'h7F, col 0.
  - Counter increments each cycle; after BLANK cycles in BLANK -> SHOW.
- SHOW:
  - row_n bit row_idx = 0, all others 1.
  - col = shadow[5*row_idx+4 : 5*row_idx].
  - Slot ends when counter reaches DIV-1; the counter counts the whole slot, BLANK plus SHOW, so every slot is exactly DIV cycles.
- Slot end:
  - Counter reset to 0, state -> BLANK, row_idx increments.
  - Wrap-around: row_idx 6 -> 0; this re-latches the shadow and pulses frame_start.
- Latching and tearing:
  - pattern_in is sampled only at frame start.
  - Changes mid-frame appear at the next frame, never mid-frame.
- enable low in any state:
  - Next edge -> IDLE, outputs dark, row_idx 0, counter 0.
  - The current frame is abandoned.
  - Re-enable starts a fresh frame at row 0 with a new latch.
- Simultaneous events:
  - rst_n low wins over everything.
  - enable low wins over slot end and wrap-around.
- Invariant: at most one row_n bit is 0 at any time; row_n is never 0 during BLANK.
- Frame period = 7*DIV cycles.

Decomposition:
- Shared package holds:
  - ROWS=7, COLS=5;
  - state encoding: IDLE=2'd0, BLANK=2'd1, SHOW=2'd2;
  - ROW_OFF=7'h7F.
- One natural sub-module, row_slot_counter: parameterised DIV/BLANK counter with outputs blank_done and slot_end, and a clear input.
- Row decode and column mux stay in the top level.

Test Plan (DIV=4, BLANK=1 unless stated):
- Reset: rst_n=0 for 3 cycles with enable=1 -> row_n=7'h7F, col=0, row_idx=0, frame_start=0 throughout.
- Basic scan: pattern_in row r = 5'b10001 XOR r, enable=1 -> in row r's slot:
  - 1 blank cycle with row_n=7'h7F;
  - then 3 cycles with row_n=~(7'b1<<r) and col=5'b10001^r;
  - after row 6, row 0 repeats with frame_start pulsed once per 28 cycles.
- Tear-free latch: change pattern_in row 2 to 5'b11111 while row 3 is showing -> row 2 keeps its old value this frame and shows 5'b11111 only after the next frame_start.
- Mid-frame disable: enable=0 during row 4 SHOW -> next cycle row_n=7'h7F, col=0, row_idx=0; enable=1 -> frame_start=1, row 0 slot begins.
- Reset mid-scan: rst_n=0 for one edge during row 5 SHOW -> all outputs at reset values; restart at row 0 with frame_start.
- Ghosting invariant: DIV=6, BLANK=2, random pattern_in and enable over 2000 cycles -> row_n is never more than one bit low, is 7'h7F in every BLANK cycle, and col=0 whenever row_n=7'h7F.
